reboot_request_ctrl: RTL



---
 rtl/reboot_request_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/reboot_request_ctrl.sv
// Reboot request front-end: debounced long-press button plus host request, grace period, sticky boot_core.
// Optional host_req/host_cancel path enabled by defining REBOOT_HOST_REQ_EN.
module reboot_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int HOLD_CYCLES     = 16777216,
  parameter int GRACE_CYCLES    = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic host_req,
  input  logic host_cancel,
  input  logic busy,
  output logic pending,
  output logic hold_active,
  output logic boot_core
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES);
  localparam int GRACE_W = $clog2(GRACE_CYCLES);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GRACE_W-1:0] GRACE_LAST = GRACE_W'(GRACE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_GRACE = 2'd2;
  localparam logic [1:0] ST_FIRE  = 2'd3;

  logic host_req_en;
  logic host_cancel_en;

`ifdef REBOOT_HOST_REQ_EN
  assign host_req_en    = host_req;
  assign host_cancel_en = host_cancel;
`else
  logic unused_host;
  assign host_req_en    = 1'b0;
  assign host_cancel_en = 1'b0;
  assign unused_host    = host_req ^ host_cancel;
`endif

  logic btn_sync1;
  logic btn_sync2;
  logic btn_level;
  logic btn_db;
  logic [DB_W-1:0] db_cnt;

  // Synchronizer idles at 1 so reset never looks like a press.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync1 <= 1'b1;
      btn_sync2 <= 1'b1;
    end else begin
      btn_sync1 <= btn_n;
      btn_sync2 <= btn_sync1;
    end
  end

  assign btn_level = ~btn_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_level == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_level;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_cnt_next;
  logic [GRACE_W-1:0] grace_cnt;
  logic [GRACE_W-1:0] grace_cnt_next;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    hold_cnt_next  = hold_cnt;
    grace_cnt_next = grace_cnt;
    case (state)
      ST_IDLE: begin
        if (host_req_en) begin
          state_next     = ST_GRACE;
          grace_cnt_next = '0;
        end else if (btn_db) begin
          state_next    = ST_HOLD;
          hold_cnt_next = '0;
        end
      end
      ST_HOLD: begin
        if (host_req_en) begin
          state_next     = ST_GRACE;
          grace_cnt_next = '0;
        end else if (!btn_db) begin
          state_next = ST_IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next     = ST_GRACE;
          grace_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt + HOLD_W'(1);
        end
      end
      ST_GRACE: begin
        // Cancel outranks the terminal count in the same cycle.
        if (host_cancel_en) begin
          state_next = ST_IDLE;
        end else if (!busy) begin
          if (grace_cnt == GRACE_LAST) begin
            state_next = ST_FIRE;
          end else begin
            grace_cnt_next = grace_cnt + GRACE_W'(1);
          end
        end
      end
      ST_FIRE: state_next = ST_FIRE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      grace_cnt   <= '0;
      pending     <= 1'b0;
      hold_active <= 1'b0;
      boot_core   <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_cnt_next;
      grace_cnt   <= grace_cnt_next;
      pending     <= (state_next == ST_GRACE) || (state_next == ST_FIRE);
      hold_active <= (state_next == ST_HOLD);
      boot_core   <= (state_next == ST_FIRE);
    end
  end

endmodule
